load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 41 ++++
 rtl/lsu_align.sv | 39 +++
 rtl/load_store_unit.sv | 155 +++++++++++++++
 tb/tb_load_store_unit.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM states, funct3 codes and
// access-size decode helpers.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Only the low two bits pick the size; 011/110/111 fall through to word.
    function automatic lsu_size_t size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   size_of = SZ_B;
            2'b01:   size_of = SZ_H;
            default: size_of = SZ_W;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (size_of(f3))
            SZ_H:    is_misaligned = off[0];
            SZ_W:    is_misaligned = |off;
            default: is_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: merges store data into a memory word and
// extracts/extends a load result from a memory word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] word,
    input  logic [31:0] sdata,
    output logic [31:0] merged,
    output logic [31:0] extended
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic        is_signed;

    assign lane_b    = word[{off, 3'b000} +: 8];
    assign lane_h    = word[{off[1], 4'b0000} +: 16];
    assign is_signed = ~funct3[2];

    always_comb begin
        merged = word;
        case (size_of(funct3))
            SZ_B:    merged[{off, 3'b000} +: 8]     = sdata[7:0];
            SZ_H:    merged[{off[1], 4'b0000} +: 16] = sdata[15:0];
            default: merged = sdata;
        endcase
    end

    always_comb begin
        case (size_of(funct3))
            SZ_B:    extended = {{24{is_signed & lane_b[7]}}, lane_b};
            SZ_H:    extended = {{16{is_signed & lane_h[15]}}, lane_h};
            default: extended = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit for a single-ported, combinational-read data memory.
// Define LSU_MISALIGN_TRAP_EN to flag misaligned accesses instead of masking the address.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reqValid,
    input  logic              reqWrite,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] reqAddr,
    input  logic [31:0]       reqData,
    output logic              busy,
    output logic              respValid,
    output logic [31:0]       loadData,
    output logic              misalign,
    output logic              memRead,
    output logic              memWrite,
    output logic [ADDR_W-1:0] memAddr,
    output logic [31:0]       memWData,
    input  logic [31:0]       memRData
);

    lsu_state_t        state_q, state_d;
    logic              write_q, write_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       word_q, word_d;
    logic [31:0]       load_data_q, load_data_d;
    logic [ADDR_W-1:0] addr_eff;
    logic              trap;
    logic [31:0]       align_word;
    logic [31:0]       merged;
    logic [31:0]       extended;
`ifdef LSU_MISALIGN_TRAP_EN
    logic              misalign_q, misalign_d;
`endif

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap     = is_misaligned(funct3, reqAddr[1:0]);
    assign addr_eff = reqAddr;
`else
    // Offending low bits are dropped so the access lands on its natural boundary.
    assign trap = 1'b0;
    always_comb begin
        addr_eff = reqAddr;
        case (size_of(funct3))
            SZ_H:    addr_eff[0]   = 1'b0;
            SZ_W:    addr_eff[1:0] = 2'b00;
            default: addr_eff      = reqAddr;
        endcase
    end
`endif

    // In RD the word is still on the bus, so extract straight from memRData.
    assign align_word = (state_q == ST_RD) ? memRData : word_q;

    lsu_align u_align (
        .funct3   (funct3_q),
        .off      (addr_q[1:0]),
        .word     (align_word),
        .sdata    (wdata_q),
        .merged   (merged),
        .extended (extended)
    );

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        word_d      = word_q;
        load_data_d = load_data_q;
`ifdef LSU_MISALIGN_TRAP_EN
        misalign_d  = misalign_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (reqValid) begin
                    write_d  = reqWrite;
                    funct3_d = funct3;
                    addr_d   = addr_eff;
                    wdata_d  = reqData;
`ifdef LSU_MISALIGN_TRAP_EN
                    misalign_d = trap;
`endif
                    if (trap) begin
                        state_d     = ST_RESP;
                        load_data_d = 32'h0;
                    end else if (reqWrite && size_of(funct3) == SZ_W) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                word_d = memRData;
                if (write_q) begin
                    state_d = ST_WR;
                end else begin
                    state_d     = ST_RESP;
                    load_data_d = extended;
                end
            end
            ST_WR:   state_d = ST_RESP;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            write_q     <= 1'b0;
            funct3_q    <= 3'b000;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
            word_q      <= 32'h0;
            load_data_q <= 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            word_q      <= word_d;
            load_data_q <= load_data_d;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_q  <= misalign_d;
`endif
        end
    end

    // Strobes are pure state decodes so reset drops them without waiting for an edge.
    assign busy      = ((state_q == ST_IDLE) && reqValid) || (state_q == ST_RD) || (state_q == ST_WR);
    assign respValid = (state_q == ST_RESP);
    assign memRead   = (state_q == ST_RD);
    assign memWrite  = (state_q == ST_WR);
    assign memAddr   = {addr_q[ADDR_W-1:2], 2'b00};
    assign memWData  = (state_q == ST_WR) ? merged : 32'h0;
    assign loadData  = load_data_q;
`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign  = respValid & misalign_q;
`else
    assign misalign  = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural combinational-read memory.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        reqValid, reqWrite;
    logic [2:0]  funct3;
    logic [31:0] reqAddr, reqData;
    logic        busy, respValid, misalign, memRead, memWrite;
    logic [31:0] loadData, memAddr, memWData, memRData;

    logic [31:0] mem [0:63];

    typedef struct {
        logic [31:0] data;
        int          lat;
        logic        mis;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .reqValid  (reqValid),
        .reqWrite  (reqWrite),
        .funct3    (funct3),
        .reqAddr   (reqAddr),
        .reqData   (reqData),
        .busy      (busy),
        .respValid (respValid),
        .loadData  (loadData),
        .misalign  (misalign),
        .memRead   (memRead),
        .memWrite  (memWrite),
        .memAddr   (memAddr),
        .memWData  (memWData),
        .memRData  (memRData)
    );

    assign memRData = mem[memAddr[7:2]];
    always @(posedge clk) if (memWrite) mem[memAddr[7:2]] <= memWData;

    // Drives one request and records what the DUT did, cycle by cycle after acceptance.
    task automatic run_req(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                           output int lat, output logic [7:0] rdm, output logic [7:0] wrm,
                           output logic [31:0] wd, output logic [31:0] ld, output logic mis);
        lat = -1; rdm = '0; wrm = '0; wd = '0; ld = '0; mis = 1'b0;
        reqWrite = w; funct3 = f3; reqAddr = a; reqData = d; reqValid = 1'b1;
        @(negedge clk);
        rdm[0] = memRead; wrm[0] = memWrite;
        @(posedge clk); #1 reqValid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k < 8) begin rdm[k] = memRead; wrm[k] = memWrite; end
            if (memWrite) wd = memWData;
            if (respValid) begin lat = k; ld = loadData; mis = misalign; break; end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if ({busy, respValid, misalign, memRead, memWrite} !== 5'b0) begin
            n_err++; $display("FAIL reset_ctrl got %b want 00000", {busy, respValid, misalign, memRead, memWrite});
        end
        n_cmp++;
        if (memAddr !== 32'h0 || memWData !== 32'h0 || loadData !== 32'h0) begin
            n_err++; $display("FAIL reset_data got addr=%h wd=%h ld=%h want 0", memAddr, memWData, loadData);
        end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_load_word();
        int lat; logic [7:0] rdm, wrm; logic [31:0] wd, ld; logic mis; exp_t e;
        sb_q.push_back('{data: 32'h8899AABB, lat: 2, mis: 1'b0});
        run_req(1'b0, 3'b010, 32'h10, 32'h0, lat, rdm, wrm, wd, ld, mis);
        e = sb_q.pop_front();
        n_cmp++;
        if (lat !== e.lat) begin n_err++; $display("FAIL lw_latency got %0d want %0d", lat, e.lat); end
        n_cmp++;
        if (ld !== e.data) begin n_err++; $display("FAIL lw_data got %h want %h", ld, e.data); end
        n_cmp++;
        if (rdm !== 8'b0000_0010 || wrm !== 8'b0) begin
            n_err++; $display("FAIL lw_strobes got rd=%b wr=%b want rd=00000010 wr=00000000", rdm, wrm);
        end
        n_cmp++;
        if (mis !== 1'b0) begin n_err++; $display("FAIL lw_misalign got %b want 0", mis); end
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3s [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] as  [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
        logic [31:0] xs  [4] = '{32'hFFFFFF88, 32'h00000088, 32'hFFFF8899, 32'h0000AABB};
        int lat; logic [7:0] rdm, wrm; logic [31:0] wd, ld; logic mis; exp_t e;
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back('{data: xs[i], lat: 2, mis: 1'b0});
            run_req(1'b0, f3s[i], as[i], 32'h0, lat, rdm, wrm, wd, ld, mis);
            e = sb_q.pop_front();
            n_cmp++;
            if (ld !== e.data || lat !== e.lat) begin
                n_err++; $display("FAIL load_ext[%0d] got data=%h lat=%0d want data=%h lat=%0d", i, ld, lat, e.data, e.lat);
            end
        end
    endtask

    task automatic test_store();
        int lat; logic [7:0] rdm, wrm; logic [31:0] wd, ld; logic mis; exp_t e;
        // sb: loadData must keep the previous load result (0x0000AABB)
        sb_q.push_back('{data: 32'h8899CCBB, lat: 3, mis: 1'b0});
        run_req(1'b1, 3'b000, 32'h11, 32'h000000CC, lat, rdm, wrm, wd, ld, mis);
        e = sb_q.pop_front();
        n_cmp++;
        if (lat !== e.lat) begin n_err++; $display("FAIL sb_latency got %0d want %0d", lat, e.lat); end
        n_cmp++;
        if (rdm !== 8'b0000_0010 || wrm !== 8'b0000_0100) begin
            n_err++; $display("FAIL sb_strobes got rd=%b wr=%b want rd=00000010 wr=00000100", rdm, wrm);
        end
        n_cmp++;
        if (wd !== e.data) begin n_err++; $display("FAIL sb_wdata got %h want %h", wd, e.data); end
        n_cmp++;
        if (ld !== 32'h0000AABB) begin n_err++; $display("FAIL sb_loaddata_held got %h want 0000aabb", ld); end

        sb_q.push_back('{data: 32'h8899CCBB, lat: 2, mis: 1'b0});
        run_req(1'b0, 3'b010, 32'h10, 32'h0, lat, rdm, wrm, wd, ld, mis);
        e = sb_q.pop_front();
        n_cmp++;
        if (ld !== e.data) begin n_err++; $display("FAIL lw_after_sb got %h want %h", ld, e.data); end

        // sh into upper half, funct3 101 treated as half for stores
        sb_q.push_back('{data: 32'h1234CCBB, lat: 3, mis: 1'b0});
        run_req(1'b1, 3'b101, 32'h12, 32'hFFFF1234, lat, rdm, wrm, wd, ld, mis);
        e = sb_q.pop_front();
        n_cmp++;
        if (wd !== e.data || lat !== e.lat) begin
            n_err++; $display("FAIL sh_merge got wd=%h lat=%0d want wd=%h lat=%0d", wd, lat, e.data, e.lat);
        end

        // sw via funct3 111 goes straight to WR
        sb_q.push_back('{data: 32'hCAFEF00D, lat: 2, mis: 1'b0});
        run_req(1'b1, 3'b111, 32'h14, 32'hCAFEF00D, lat, rdm, wrm, wd, ld, mis);
        e = sb_q.pop_front();
        n_cmp++;
        if (wd !== e.data || lat !== e.lat || rdm !== 8'b0 || wrm !== 8'b0000_0010) begin
            n_err++; $display("FAIL sw_direct got wd=%h lat=%0d rd=%b wr=%b want wd=%h lat=%0d rd=00000000 wr=00000010",
                              wd, lat, rdm, wrm, e.data, e.lat);
        end
        n_cmp++;
        if (mem[5] !== 32'hCAFEF00D) begin n_err++; $display("FAIL sw_mem got %h want cafef00d", mem[5]); end
    endtask

    task automatic test_misalign();
        int lat; logic [7:0] rdm, wrm; logic [31:0] wd, ld; logic mis; exp_t e;
`ifdef LSU_MISALIGN_TRAP_EN
        sb_q.push_back('{data: 32'h0, lat: 1, mis: 1'b1});
`else
        sb_q.push_back('{data: 32'h1234CCBB, lat: 2, mis: 1'b0});
`endif
        run_req(1'b0, 3'b010, 32'h12, 32'h0, lat, rdm, wrm, wd, ld, mis);
        e = sb_q.pop_front();
        n_cmp++;
        if (ld !== e.data || lat !== e.lat || mis !== e.mis) begin
            n_err++; $display("FAIL lw_misaligned got data=%h lat=%0d mis=%b want data=%h lat=%0d mis=%b",
                              ld, lat, mis, e.data, e.lat, e.mis);
        end
`ifdef LSU_MISALIGN_TRAP_EN
        n_cmp++;
        if (rdm !== 8'b0 || wrm !== 8'b0) begin
            n_err++; $display("FAIL misalign_strobes got rd=%b wr=%b want 0", rdm, wrm);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int lat; logic [7:0] rdm, wrm; logic [31:0] wd, ld; logic mis;
        mem[8] = 32'hDEADBEEF;
        reqWrite = 1'b1; funct3 = 3'b010; reqAddr = 32'h20; reqData = 32'h12345678; reqValid = 1'b1;
        @(posedge clk); #1 reqValid = 1'b0;
        n_cmp++;
        if (memWrite !== 1'b1) begin n_err++; $display("FAIL rst_mid_in_wr got memWrite=%b want 1", memWrite); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, respValid, misalign, memRead, memWrite} !== 5'b0 || memAddr !== 32'h0 ||
            memWData !== 32'h0 || loadData !== 32'h0) begin
            n_err++; $display("FAIL rst_mid_outputs got ctl=%b addr=%h wd=%h ld=%h want all 0",
                              {busy, respValid, misalign, memRead, memWrite}, memAddr, memWData, loadData);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (mem[8] !== 32'hDEADBEEF) begin n_err++; $display("FAIL rst_mid_mem got %h want deadbeef", mem[8]); end
        rst_n = 1'b1;
        run_req(1'b0, 3'b010, 32'h20, 32'h0, lat, rdm, wrm, wd, ld, mis);
        n_cmp++;
        if (ld !== 32'hDEADBEEF || lat !== 2) begin
            n_err++; $display("FAIL rst_mid_recover got data=%h lat=%0d want deadbeef 2", ld, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] resp_m = '0;
        exp_t e;
        sb_q.push_back('{data: 32'h1234CCBB, lat: 2, mis: 1'b0});
        sb_q.push_back('{data: 32'h000000BB, lat: 5, mis: 1'b0});
        reqWrite = 1'b0; funct3 = 3'b010; reqAddr = 32'h10; reqValid = 1'b1;
        @(posedge clk); #1 funct3 = 3'b100;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 2) begin
                n_cmp++;
                if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_busy_resp got %b want 0", busy); end
            end
            if (k == 3) begin
                n_cmp++;
                if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy_idle got %b want 1", busy); end
            end
            if (respValid) begin
                resp_m[k] = 1'b1;
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_err++; $display("FAIL b2b_extra_resp at cycle %0d want none", k);
                end else begin
                    e = sb_q.pop_front();
                    if (loadData !== e.data || k !== e.lat) begin
                        n_err++; $display("FAIL b2b_resp got data=%h cyc=%0d want data=%h cyc=%0d", loadData, k, e.data, e.lat);
                    end
                end
            end
            if (k == 3) begin @(posedge clk); #1 reqValid = 1'b0; end
        end
        n_cmp++;
        if (resp_m !== 8'b0010_0100) begin n_err++; $display("FAIL b2b_resp_pattern got %b want 00100100", resp_m); end
        n_cmp++;
        if (sb_q.size() != 0) begin n_err++; $display("FAIL b2b_missing_resp got %0d left want 0", sb_q.size()); end
        sb_q.delete();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[4] = 32'h8899AABB;
        rst_n = 1'b0; reqValid = 1'b0; reqWrite = 1'b0; funct3 = 3'b000; reqAddr = 32'h0; reqData = 32'h0;
        repeat (2) @(posedge clk);
        test_reset();
        test_load_word();
        test_load_ext();
        test_store();
        test_misalign();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
